priority_encoder_nx_reg: RTL

PRIORITY_ENCODER_NX_REG -- requirements
Module: priority_encoder_nx_reg

---
 rtl/priority_encoder_nx_reg.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/priority_encoder_nx_reg.sv
// Registered N-input priority encoder with a single-entry valid/ready output stage.
// MODE 0 picks the highest set index; MODE 1 searches downward from a rotating pointer.
module priority_encoder_nx_reg #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] grant,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_q, out_d;
  logic         valid_q, valid_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         load_s;
  logic         any_s;
  logic [W-1:0] win_s;
  logic [W-1:0] ptr_next_s;

  // Remap the request so bit N-1 is the pointer position and lower bits follow
  // the descending, wrapping search order.
  function automatic logic [N-1:0] rotate_req(input logic [N-1:0] req,
                                              input logic [W-1:0] p);
    logic [N-1:0] r;
    int           s;
    r = '0;
    for (int j = 0; j < N; j++) begin
      s = j + int'(p) + 1;
      if (s >= N) begin
        s = s - N;
      end else begin
        s = s;
      end
      r[j] = req[s];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] highest_set(input logic [N-1:0] req);
    logic [W-1:0] idx;
    idx = '0;
    for (int j = 0; j < N; j++) begin
      if (req[j]) begin
        idx = W'(j);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Map a position in the rotated vector back to the original request index.
  function automatic logic [W-1:0] unrotate_idx(input logic [W-1:0] j,
                                                input logic [W-1:0] p);
    int s;
    s = int'(j) + int'(p) + 1;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return W'(s);
  endfunction

  assign in_ready  = !out_valid_q | out_ready;
  assign load_s    = in_valid & in_ready;
  assign any_s     = |in;
  assign out       = out_q;
  assign valid     = valid_q;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;

  // Winner selection for the sample currently presented on in.
  always_comb begin
    win_s = '0;
    if (MODE == 0) begin
      win_s = highest_set(in);
    end else begin
      win_s = unrotate_idx(highest_set(rotate_req(in, ptr_q)), ptr_q);
    end
  end

  // Pointer moves just below the winner; index 0 wraps to the top.
  always_comb begin
    ptr_next_s = '0;
    if (win_s == '0) begin
      ptr_next_s = W'(N - 1);
    end else begin
      ptr_next_s = win_s - W'(1);
    end
  end

  // Output-register next state: load, drain, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    valid_d     = valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      valid_d     = any_s;
      out_d       = any_s ? win_s : '0;
      for (int j = 0; j < N; j++) begin
        grant_d[j] = any_s && (win_s == W'(j));
      end
      if (any_s) begin
        ptr_d = ptr_next_s;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset overrides any concurrent load or accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule
